// File: rtl/wb_write_arbiter_if.sv
// Write-back bus between the ALU/load sources and the register-file arbiter.
// Optional forwarding lookup ports are present only when WB_FWD_EN is defined.
interface wb_write_arbiter_if;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        mem_valid;
    logic [2:0]  mem_dest;
    logic [15:0] mem_data;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        alu_stall;
    logic [1:0]  pend_count;
`ifdef WB_FWD_EN
    logic [2:0]  fwd_addr;
    logic        fwd_hit;
    logic [15:0] fwd_data;
`endif

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  rf_we, rf_waddr, rf_wdata, alu_stall, pend_count
`ifdef WB_FWD_EN
        ,
        output fwd_addr,
        input  fwd_hit, fwd_data
`endif
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output rf_we, rf_waddr, rf_wdata, alu_stall, pend_count
`ifdef WB_FWD_EN
        ,
        input  fwd_addr,
        output fwd_hit, fwd_data
`endif
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single-port register-file write arbiter: load returns win, ALU results queue in a 2-entry FIFO.
// Define WB_FWD_EN to add the combinational forwarding lookup (fwd_addr/fwd_hit/fwd_data).
module wb_write_arbiter (
    input  logic                clk,
    input  logic                rst,
    wb_write_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  head_dest;
    logic [15:0] head_data;
    logic [2:0]  tail_dest;
    logic [15:0] tail_data;

    logic        stall;
    logic        mem_ok;
    logic        alu_acc;
    logic        alu_ok;
    logic        head_vld;
    logic        pop;
    logic        push;

    logic        sel_we;
    logic [2:0]  sel_addr;
    logic [15:0] sel_data;

    logic        rf_we_q;
    logic [2:0]  rf_waddr_q;
    logic [15:0] rf_wdata_q;

    // Requests to register 0 are accepted but never consume the port or the FIFO.
    assign mem_ok   = bus.mem_valid && (bus.mem_dest != 3'd0);
    assign alu_acc  = bus.alu_valid && !stall;
    assign alu_ok   = alu_acc && (bus.alu_dest != 3'd0);
    assign head_vld = (state != EMPTY);
    assign pop      = !mem_ok && head_vld;
    assign push     = alu_ok && (mem_ok || head_vld);

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = 3'd0;
        sel_data = 16'd0;
        if (mem_ok) begin
            sel_we   = 1'b1;
            sel_addr = bus.mem_dest;
            sel_data = bus.mem_data;
        end else if (head_vld) begin
            sel_we   = 1'b1;
            sel_addr = head_dest;
            sel_data = head_data;
        end else if (alu_ok) begin
            sel_we   = 1'b1;
            sel_addr = bus.alu_dest;
            sel_data = bus.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            head_dest <= 3'd0;
            head_data <= 16'd0;
            tail_dest <= 3'd0;
            tail_data <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_dest <= bus.alu_dest;
                        head_data <= bus.alu_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_dest <= bus.alu_dest;
                        head_data <= bus.alu_data;
                    end else if (push) begin
                        tail_dest <= bus.alu_dest;
                        tail_data <= bus.alu_data;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_dest <= tail_dest;
                        head_data <= tail_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Push is impossible in FULL because the ALU is stalled there.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL:  if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        stall          = (state == FULL);
        bus.alu_stall  = stall;
        case (state)
            ONE:     bus.pend_count = 2'd1;
            FULL:    bus.pend_count = 2'd2;
            default: bus.pend_count = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= 3'd0;
            rf_wdata_q <= 16'd0;
        end else begin
            rf_we_q    <= sel_we;
            rf_waddr_q <= sel_addr;
            rf_wdata_q <= sel_data;
        end
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_FWD_EN
    // Youngest value wins: FIFO tail, then head, then the write in flight to the register file.
    always_comb begin
        bus.fwd_hit  = 1'b0;
        bus.fwd_data = 16'd0;
        if (bus.fwd_addr != 3'd0) begin
            if ((state == FULL) && (tail_dest == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = tail_data;
            end else if (head_vld && (head_dest == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = head_data;
            end else if (rf_we_q && (rf_waddr_q == bus.fwd_addr)) begin
                bus.fwd_hit  = 1'b1;
                bus.fwd_data = rf_wdata_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter; forwarding checks compile in when WB_FWD_EN is defined.
module tb_wb_write_arbiter;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    wb_write_arbiter_if bus ();

    wb_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic av, input logic [2:0] ad, input logic [15:0] adata,
                                 input logic mv, input logic [2:0] md, input logic [15:0] mdata);
        bus.alu_valid = av;
        bus.alu_dest  = ad;
        bus.alu_data  = adata;
        bus.mem_valid = mv;
        bus.mem_dest  = md;
        bus.mem_data  = mdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [2:0] addr,
                              input logic [15:0] data, input logic [1:0] pend);
        checkOutput({tag, ".we"}, 16'(bus.rf_we), 16'(we));
        if (we) begin
            checkOutput({tag, ".addr"}, 16'(bus.rf_waddr), 16'(addr));
            checkOutput({tag, ".data"}, bus.rf_wdata, data);
        end
        checkOutput({tag, ".pend"}, 16'(bus.pend_count), 16'(pend));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
`ifdef WB_FWD_EN
        bus.fwd_addr = 3'd0;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst.we",    16'(bus.rf_we), 16'h0);
        checkOutput("rst.addr",  16'(bus.rf_waddr), 16'h0);
        checkOutput("rst.data",  bus.rf_wdata, 16'h0);
        checkOutput("rst.pend",  16'(bus.pend_count), 16'h0);
        checkOutput("rst.stall", 16'(bus.alu_stall), 16'h0);

        // Scenario 1: lone ALU write goes straight through
        applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s1.wr", 1'b1, 3'd3, 16'h1234, 2'd0);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s1.idle", 1'b0, 3'd0, 16'h0, 2'd0);

        // Scenario 2: mem and ALU collide, ALU is buffered one cycle
        applyStimulus(1'b1, 3'd5, 16'h0055, 1'b1, 3'd2, 16'hAAAA);
        tick();
        checkWrite("s2.mem", 1'b1, 3'd2, 16'hAAAA, 2'd1);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s2.alu", 1'b1, 3'd5, 16'h0055, 2'd0);
        tick();
        checkWrite("s2.idle", 1'b0, 3'd0, 16'h0, 2'd0);

        // Scenario 3: four mem cycles fill the FIFO and stall the third ALU request
        applyStimulus(1'b1, 3'd1, 16'h0101, 1'b1, 3'd7, 16'h1000);
        tick();
        checkWrite("s3.m1", 1'b1, 3'd7, 16'h1000, 2'd1);
        applyStimulus(1'b1, 3'd2, 16'h0202, 1'b1, 3'd7, 16'h1001);
        checkOutput("s3.nostall", 16'(bus.alu_stall), 16'h0);
        tick();
        checkWrite("s3.m2", 1'b1, 3'd7, 16'h1001, 2'd2);
        applyStimulus(1'b1, 3'd3, 16'h0303, 1'b1, 3'd7, 16'h1002);
        checkOutput("s3.stall", 16'(bus.alu_stall), 16'h1);
        tick();
        checkWrite("s3.m3", 1'b1, 3'd7, 16'h1002, 2'd2);
        applyStimulus(1'b1, 3'd3, 16'h0303, 1'b1, 3'd7, 16'h1003);
        tick();
        checkWrite("s3.m4", 1'b1, 3'd7, 16'h1003, 2'd2);
        applyStimulus(1'b1, 3'd3, 16'h0303, 1'b0, 3'd0, 16'h0);
        checkOutput("s3.stall2", 16'(bus.alu_stall), 16'h1);
        tick();
        checkWrite("s3.w1", 1'b1, 3'd1, 16'h0101, 2'd1);
        checkOutput("s3.unstall", 16'(bus.alu_stall), 16'h0);
        tick();
        checkWrite("s3.w2", 1'b1, 3'd2, 16'h0202, 2'd1);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s3.w3", 1'b1, 3'd3, 16'h0303, 2'd0);
        tick();
        checkWrite("s3.idle", 1'b0, 3'd0, 16'h0, 2'd0);

        // Scenario 4: dest 0 is discarded and a dest-0 load does not block the ALU
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s4.alu0", 1'b0, 3'd0, 16'h0, 2'd0);
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 16'hFFFF);
        tick();
        checkWrite("s4.both0", 1'b0, 3'd0, 16'h0, 2'd0);
        applyStimulus(1'b1, 3'd4, 16'h0044, 1'b1, 3'd0, 16'hBEEF);
        tick();
        checkWrite("s4.mem0", 1'b1, 3'd4, 16'h0044, 2'd0);

        // Scenario 5: reset with a full FIFO drops both entries
        applyStimulus(1'b1, 3'd1, 16'h0A01, 1'b1, 3'd7, 16'h2000);
        tick();
        applyStimulus(1'b1, 3'd2, 16'h0A02, 1'b1, 3'd7, 16'h2001);
        tick();
        checkWrite("s5.full", 1'b1, 3'd7, 16'h2001, 2'd2);
        rst = 1'b1;
        applyStimulus(1'b1, 3'd5, 16'h0A05, 1'b1, 3'd6, 16'h2002);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        checkWrite("s5.rst", 1'b0, 3'd0, 16'h0, 2'd0);
        checkOutput("s5.stall", 16'(bus.alu_stall), 16'h0);
        checkOutput("s5.addr", 16'(bus.rf_waddr), 16'h0);
        tick();
        checkWrite("s5.drop1", 1'b0, 3'd0, 16'h0, 2'd0);
        tick();
        checkWrite("s5.drop2", 1'b0, 3'd0, 16'h0, 2'd0);

`ifdef WB_FWD_EN
        // Scenario 6: two buffered writes to r4, youngest (tail) is forwarded
        applyStimulus(1'b1, 3'd4, 16'h0001, 1'b1, 3'd7, 16'h3000);
        tick();
        applyStimulus(1'b1, 3'd4, 16'h0002, 1'b1, 3'd7, 16'h3001);
        tick();
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h3002);
        bus.fwd_addr = 3'd4;
        #1;
        checkOutput("s6.pend", 16'(bus.pend_count), 16'h2);
        checkOutput("s6.hit", 16'(bus.fwd_hit), 16'h1);
        checkOutput("s6.data", bus.fwd_data, 16'h0002);
        bus.fwd_addr = 3'd0;
        #1;
        checkOutput("s6.hit0", 16'(bus.fwd_hit), 16'h0);
        bus.fwd_addr = 3'd7;
        #1;
        checkOutput("s6.rfhit", 16'(bus.fwd_hit), 16'h1);
        checkOutput("s6.rfdata", bus.fwd_data, 16'h3001);
        bus.fwd_addr = 3'd5;
        #1;
        checkOutput("s6.miss", 16'(bus.fwd_hit), 16'h0);
        bus.fwd_addr = 3'd0;
        tick();
        checkWrite("s6.m3", 1'b1, 3'd6, 16'h3002, 2'd2);
        applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
        tick();
        checkWrite("s6.w1", 1'b1, 3'd4, 16'h0001, 2'd1);
        tick();
        checkWrite("s6.w2", 1'b1, 3'd4, 16'h0002, 2'd0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
